// File: rtl/uart_rx_core.sv
// UART receiver core: 16x-oversampled start/data/parity/stop recovery with a
// valid/read byte handshake plus parity, framing and overrun flags.
module uart_rx_core #(
    parameter int TIMER_BITS = 10,
    parameter int DATA_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  rx_en,
    input  logic [TIMER_BITS-1:0] Load_Value,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  rx_in,
    input  logic                  rx_read,
    output logic [DATA_BITS-1:0]  rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  rx_busy
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_nx;

    logic                  sync1, rx_s, rx_prev;
    logic [TIMER_BITS-1:0] timer, load_q;
    logic [3:0]            cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_BITS-1:0]  shift;
    logic                  par_bad;

    logic tick, mid_tick, bit_tick, start_det;
    logic sample_data, sample_par, commit;

    // NOTE: synchronizer and edge-history flops reset to the idle-high line
    // level so that leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_in;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign tick      = (state != IDLE) && (timer == load_q);
    assign mid_tick  = tick && (cnt == 4'd7);
    assign bit_tick  = tick && (cnt == 4'hF);
    // A start needs a seen-high-then-low edge, so a line held low never re-arms.
    assign start_det = rx_en && rx_prev && !rx_s;

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nx;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        if (!rx_en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_det) state_nx = START;
                START:   if (mid_tick)  state_nx = rx_s ? IDLE : DATA;
                DATA:    if (bit_tick && (bit_idx == LAST_BIT))
                             state_nx = parity_en ? PARITY : STOP;
                PARITY:  if (bit_tick)  state_nx = STOP;
                STOP:    if (bit_tick)  state_nx = IDLE;
                default:                state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_busy     = (state != IDLE);
        sample_data = 1'b0;
        sample_par  = 1'b0;
        commit      = 1'b0;
        if (rx_en && bit_tick) begin
            sample_data = (state == DATA);
            sample_par  = (state == PARITY);
            commit      = (state == STOP);
        end
    end

    // Oversample timer and mod-16 tick counter; divisor frozen for the whole frame.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            timer  <= '0;
            cnt    <= '0;
            load_q <= '0;
        end else if (state == IDLE) begin
            timer <= '0;
            cnt   <= '0;
            if (start_det) load_q <= Load_Value;
        end else if (tick) begin
            timer <= '0;
            cnt   <= ((state == START) && (cnt == 4'd7)) ? 4'd0 : cnt + 4'd1;
        end else begin
            timer <= timer + TIMER_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bit_idx <= '0;
            shift   <= '0;
            par_bad <= 1'b0;
        end else begin
            if (state == START) begin
                bit_idx <= '0;
                par_bad <= 1'b0;
            end
            if (sample_data) begin
                shift   <= {rx_s, shift[DATA_BITS-1:1]};
                bit_idx <= bit_idx + BIT_W'(1);
            end
            if (sample_par) par_bad <= ((^shift) ^ rx_s) != parity_odd;
        end
    end

    // A completing frame beats a same-cycle read: newest byte is kept and
    // overrun is only raised when the previous byte was left unread.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit) begin
            rx_data    <= shift;
            rx_valid   <= 1'b1;
            parity_err <= par_bad & parity_en;
            frame_err  <= ~rx_s;
            overrun    <= rx_valid & ~rx_read;
        end else if (rx_read) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule
